// File: rtl/riscv_run_pkg.sv
// Shared state encoding and parameter defaults for the run controller.
// Both the top level and its helpers import this package.
package riscv_run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_e;

    localparam int DEF_N_CORES    = 1;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_MAX_CYCLES = 24;

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module riscv_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: resets the cores, lets them run until every core halts
// or the cycle budget expires, and reports cycle and per-core retire counts.
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int N_CORES    = DEF_N_CORES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [N_CORES-1:0]       retire_i,
    input  logic [N_CORES-1:0]       halt_i,
    output logic                     core_rst_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [N_CORES-1:0]       halted_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [N_CORES*CNT_W-1:0] retire_cnt_o
);

    localparam logic [7:0]     RST_LOAD = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W:0] MAX_EXT  = (CNT_W + 1)'(MAX_CYCLES);

    run_state_e     state;
    run_state_e     state_nx;
    logic [7:0]     rst_cnt;
    logic [CNT_W:0] cycle_inc;
    logic           clear;
    logic           in_run;
    logic           all_halt;
    logic           budget_end;
    logic           end_timeout;

    assign in_run     = (state == RUN);
    assign clear      = ((state == IDLE) || (state == DONE)) && start_i;
    assign all_halt   = &(halted_o | halt_i);
    assign cycle_inc  = {1'b0, cycle_cnt_o} + {{CNT_W{1'b0}}, 1'b1};
    assign budget_end = (cycle_inc == MAX_EXT);

    // A halt of every core takes precedence over the budget running out.
    always_comb begin
        state_nx    = state;
        end_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nx = RESET;
            end
            RESET: begin
                if (rst_cnt == 8'd0) state_nx = RUN;
            end
            RUN: begin
                if (all_halt) begin
                    state_nx = DONE;
                end else if (budget_end) begin
                    state_nx    = DONE;
                    end_timeout = 1'b1;
                end
            end
            DONE: begin
                if (start_i) state_nx = RESET;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rst_cnt     <= 8'd0;
            cycle_cnt_o <= '0;
            halted_o    <= '0;
            timeout_o   <= 1'b0;
            core_rst_o  <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state      <= state_nx;
            core_rst_o <= (state_nx != RUN);
            busy_o     <= (state_nx == RESET) || (state_nx == RUN);
            done_o     <= (state_nx == DONE);
            if (clear) begin
                rst_cnt     <= RST_LOAD;
                cycle_cnt_o <= '0;
                halted_o    <= '0;
                timeout_o   <= 1'b0;
            end else begin
                if ((state == RESET) && (rst_cnt != 8'd0)) begin
                    rst_cnt <= rst_cnt - 8'd1;
                end
                if (in_run) begin
                    cycle_cnt_o <= cycle_inc[CNT_W-1:0];
                    halted_o    <= halted_o | halt_i;
                    timeout_o   <= end_timeout;
                end
            end
        end
    end

    for (genvar k = 0; k < N_CORES; k++) begin : g_retire
        riscv_sat_counter #(
            .CNT_W(CNT_W)
        ) u_retire_cnt (
            .clk(clk),
            .rst(rst),
            .clr(clear),
            .en (in_run && retire_i[k]),
            .cnt(retire_cnt_o[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: directed and random runs compared against a
// per-run behavioural model (retire sums, halt union, budget rule).
module tb_riscv_run_ctrl;

    localparam int MAXA = 24;
    localparam int MAXB = 255;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: two cores, default widths and budget
    logic        rst_a, start_a;
    logic [1:0]  retire_a, halt_a;
    logic        core_rst_a, busy_a, done_a, timeout_a;
    logic [1:0]  halted_a;
    logic [15:0] cycle_a;
    logic [31:0] ret_cnt_a;

    // Instance B: one core, 8-bit counters, 255-cycle budget, 3 reset cycles
    logic        rst_b, start_b;
    logic [0:0]  retire_b, halt_b;
    logic        core_rst_b, busy_b, done_b, timeout_b;
    logic [0:0]  halted_b;
    logic [7:0]  cycle_b;
    logic [7:0]  ret_cnt_b;

    riscv_run_ctrl #(.N_CORES(2), .CNT_W(16), .RST_CYCLES(2), .MAX_CYCLES(MAXA)) dut_a (
        .clk(clk), .rst(rst_a), .start_i(start_a), .retire_i(retire_a), .halt_i(halt_a),
        .core_rst_o(core_rst_a), .busy_o(busy_a), .done_o(done_a), .timeout_o(timeout_a),
        .halted_o(halted_a), .cycle_cnt_o(cycle_a), .retire_cnt_o(ret_cnt_a)
    );

    riscv_run_ctrl #(.N_CORES(1), .CNT_W(8), .RST_CYCLES(3), .MAX_CYCLES(MAXB)) dut_b (
        .clk(clk), .rst(rst_b), .start_i(start_b), .retire_i(retire_b), .halt_i(halt_b),
        .core_rst_o(core_rst_b), .busy_o(busy_b), .done_o(done_b), .timeout_o(timeout_b),
        .halted_o(halted_b), .cycle_cnt_o(cycle_b), .retire_cnt_o(ret_cnt_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [1:0] ret_pat  [1:MAXA];
    logic [1:0] halt_pat [1:MAXA];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_core_rst"}, core_rst_a, 1);
        check({tag, "_busy"},     busy_a, 0);
        check({tag, "_done"},     done_a, 0);
        check({tag, "_timeout"},  timeout_a, 0);
        check({tag, "_halted"},   halted_a, 0);
        check({tag, "_cycle"},    cycle_a, 0);
        check({tag, "_ret0"},     ret_cnt_a[15:0], 0);
        check({tag, "_ret1"},     ret_cnt_a[31:16], 0);
    endtask

    task automatic clear_pats();
        for (int i = 1; i <= MAXA; i++) begin
            ret_pat[i]  = 2'b00;
            halt_pat[i] = 2'b00;
        end
    endtask

    task automatic random_pats();
        for (int i = 1; i <= MAXA; i++) begin
            ret_pat[i]  = 2'($urandom_range(0, 3));
            halt_pat[i] = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
        end
    endtask

    // One complete run on instance A. The model: a run lasts until every core
    // has halted at least once or MAXA cycles have elapsed, halts winning ties.
    task automatic run_a(input string tag, input int rst_at, input int start_at);
        int         exp_r0, exp_r1, last;
        logic [1:0] exp_h;
        bit         fin, tout;
        exp_r0 = 0; exp_r1 = 0; exp_h = 2'b00; fin = 0; tout = 0; last = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; retire_a = 2'b11; halt_a = 2'b11;
        check({tag, "_rst1_core_rst"}, core_rst_a, 1);
        check({tag, "_rst1_busy"},     busy_a, 1);
        check({tag, "_rst1_done"},     done_a, 0);
        check({tag, "_rst1_cycle"},    cycle_a, 0);
        check({tag, "_rst1_halted"},   halted_a, 0);
        check({tag, "_rst1_ret0"},     ret_cnt_a[15:0], 0);
        check({tag, "_rst1_timeout"},  timeout_a, 0);
        @(negedge clk);
        check({tag, "_rst2_core_rst"}, core_rst_a, 1);
        check({tag, "_rst2_halted"},   halted_a, 0);
        for (int c = 1; c <= MAXA; c++) begin
            @(negedge clk);
            check({tag, "_run_core_rst"}, core_rst_a, 0);
            check({tag, "_run_busy"},     busy_a, 1);
            check({tag, "_run_done"},     done_a, 0);
            check({tag, "_run_cycle"},    cycle_a, c - 1);
            check({tag, "_run_halted"},   halted_a, exp_h);
            check({tag, "_run_ret0"},     ret_cnt_a[15:0], exp_r0);
            check({tag, "_run_ret1"},     ret_cnt_a[31:16], exp_r1);
            retire_a = ret_pat[c];
            halt_a   = halt_pat[c];
            start_a  = (c == start_at);
            rst_a    = (c == rst_at);
            if (c == rst_at) begin
                @(negedge clk);
                rst_a = 1'b0; start_a = 1'b0; retire_a = 2'b00; halt_a = 2'b00;
                check_idle_a({tag, "_midrst"});
                @(negedge clk);
                check_idle_a({tag, "_midrst_hold"});
                return;
            end
            exp_r0 += int'(ret_pat[c][0]);
            exp_r1 += int'(ret_pat[c][1]);
            exp_h  |= halt_pat[c];
            if (exp_h == 2'b11) begin
                fin = 1; tout = 0;
            end else if (c == MAXA) begin
                fin = 1; tout = 1;
            end
            if (fin) begin
                last = c;
                break;
            end
        end
        @(negedge clk);
        start_a = 1'b0; retire_a = 2'b11; halt_a = 2'b11;
        check({tag, "_done"},     done_a, 1);
        check({tag, "_busy"},     busy_a, 0);
        check({tag, "_core_rst"}, core_rst_a, 1);
        check({tag, "_timeout"},  timeout_a, tout);
        check({tag, "_cycle"},    cycle_a, last);
        check({tag, "_halted"},   halted_a, exp_h);
        check({tag, "_ret0"},     ret_cnt_a[15:0], exp_r0);
        check({tag, "_ret1"},     ret_cnt_a[31:16], exp_r1);
        @(negedge clk);
        check({tag, "_hold_done"},  done_a, 1);
        check({tag, "_hold_cycle"}, cycle_a, last);
        check({tag, "_hold_ret0"},  ret_cnt_a[15:0], exp_r0);
        check({tag, "_hold_ret1"},  ret_cnt_a[31:16], exp_r1);
        retire_a = 2'b00; halt_a = 2'b00;
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b0; retire_a = 2'b00; halt_a = 2'b00;
        rst_b = 1'b1; start_b = 1'b0; retire_b = 1'b0;  halt_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_a("por");
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check_idle_a("idle");

        // Both cores retire every cycle, both halt on cycle 10
        clear_pats();
        for (int i = 1; i <= 10; i++) ret_pat[i] = 2'b11;
        halt_pat[10] = 2'b11;
        run_a("halt10", 0, 0);

        // No halts: budget expiry after MAXA cycles
        clear_pats();
        for (int i = 1; i <= MAXA; i++) ret_pat[i] = 2'(i % 4);
        run_a("budget", 0, 0);

        // Halt lands on the last budget cycle
        clear_pats();
        halt_pat[MAXA] = 2'b11;
        run_a("tie", 0, 0);

        // Staggered halts with a stray start mid-run
        clear_pats();
        halt_pat[3] = 2'b01;
        halt_pat[7] = 2'b10;
        for (int i = 1; i <= MAXA; i++) ret_pat[i] = 2'b01;
        run_a("stagger", 0, 5);

        // Reset while running, start asserted alongside
        clear_pats();
        for (int i = 1; i <= MAXA; i++) ret_pat[i] = 2'b11;
        run_a("midrst", 4, 2);

        for (int r = 0; r < 6; r++) begin
            random_pats();
            run_a($sformatf("rnd%0d", r), 0, int'($urandom_range(0, MAXA)));
        end

        // rst and start together from DONE: rst wins
        @(negedge clk); rst_a = 1'b1; start_a = 1'b1;
        @(negedge clk); rst_a = 1'b0; start_a = 1'b0;
        check_idle_a("rst_vs_start");
        @(negedge clk);
        check_idle_a("rst_vs_start_hold");

        // Instance B: retire every cycle until the 255-cycle budget ends
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0; retire_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("b_reset_core_rst", core_rst_b, 1);
            check("b_reset_busy", busy_b, 1);
            @(negedge clk);
        end
        for (int c = 1; c <= MAXB; c++) begin
            check("b_run_core_rst", core_rst_b, 0);
            check("b_run_cycle", cycle_b, c - 1);
            check("b_run_ret", ret_cnt_b, c - 1);
            @(negedge clk);
        end
        check("b_done", done_b, 1);
        check("b_timeout", timeout_b, 1);
        check("b_cycle", cycle_b, MAXB);
        check("b_ret", ret_cnt_b, MAXB);
        @(negedge clk);
        check("b_hold_ret", ret_cnt_b, MAXB);
        check("b_hold_cycle", cycle_b, MAXB);
        check("b_hold_done", done_b, 1);
        retire_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
